// File: rtl/vector_merge_pipeline.sv
// Multi-beat vector merge/move unit: streams a register group as DATA_WIDTH-bit beats,
// applying vstart, vl, the v0 mask and the tail policy element by element.
module vector_merge_pipeline #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 8,
    parameter int MASK_WIDTH = DATA_WIDTH*MAX_BEATS/8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_sew,
    input  logic [1:0]                    cmd_mode,
    input  logic                          cmd_tail_agnostic,
    input  logic [$clog2(MASK_WIDTH):0]   cmd_vl,
    input  logic [$clog2(MASK_WIDTH)-1:0] cmd_vstart,
    input  logic [$clog2(MAX_BEATS):0]    cmd_num_beats,
    input  logic [63:0]                   cmd_scalar,
    input  logic [MASK_WIDTH-1:0]         cmd_v0,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [DATA_WIDTH-1:0]         vs2,
    input  logic [DATA_WIDTH-1:0]         vs1,
    input  logic [DATA_WIDTH-1:0]         old_vd,
    output logic                          vd_valid,
    input  logic                          vd_ready,
    output logic [DATA_WIDTH-1:0]         vd,
    output logic                          done
);
    localparam int VLW   = $clog2(MASK_WIDTH) + 1;
    localparam int VSW   = $clog2(MASK_WIDTH);
    localparam int NBW   = $clog2(MAX_BEATS) + 1;
    localparam int BYTES = DATA_WIDTH / 8;

    localparam logic [1:0] M_VVM = 2'd0, M_VXM = 2'd1, M_VMV_V = 2'd2, M_VMV_X = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_FINISH} state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_sew, r_mode;
    logic                  r_ta;
    logic [VLW-1:0]        r_vl;
    logic [VSW-1:0]        r_vstart;
    logic [NBW-1:0]        r_nb, r_beat;
    logic [7:0][7:0]       r_scalar;
    logic [MASK_WIDTH-1:0] r_v0;
    logic [DATA_WIDTH-1:0] r_vd;
    logic                  r_vd_valid, r_done;
    logic                  w_op_ready, w_op_acc, w_cmd_acc;
    logic [BYTES-1:0][7:0] w_res;

    assign cmd_ready  = (r_state == S_IDLE);
    assign w_cmd_acc  = cmd_ready && cmd_valid;
    assign w_op_ready = (r_state == S_RUN) && (!r_vd_valid || vd_ready);
    assign w_op_acc   = op_valid && w_op_ready;
    assign op_ready   = w_op_ready;
    assign vd_valid   = r_vd_valid;
    assign vd         = r_vd;
    assign done       = r_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                // Empty body: skip straight to completion without touching the operand stream
                if (cmd_valid)
                    w_next = (cmd_vl == '0 || {1'b0, cmd_vstart} >= cmd_vl) ? S_FINISH : S_RUN;
            end
            S_RUN:    if (w_op_acc && r_beat == r_nb - NBW'(1)) w_next = S_WAIT;
            S_WAIT:   if (r_vd_valid && vd_ready) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sew      <= '0;
            r_mode     <= '0;
            r_ta       <= 1'b0;
            r_vl       <= '0;
            r_vstart   <= '0;
            r_nb       <= '0;
            r_scalar   <= '0;
            r_v0       <= '0;
            r_beat     <= '0;
            r_vd       <= '0;
            r_vd_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (w_next == S_FINISH);
            if (w_cmd_acc) begin
                r_sew    <= cmd_sew;
                r_mode   <= cmd_mode;
                r_ta     <= cmd_tail_agnostic;
                r_vl     <= cmd_vl;
                r_vstart <= cmd_vstart;
                r_nb     <= cmd_num_beats;
                r_scalar <= cmd_scalar;
                r_v0     <= cmd_v0;
                r_beat   <= '0;
            end else if (w_op_acc) begin
                r_beat <= r_beat + NBW'(1);
            end
            if (w_op_acc) begin
                r_vd       <= w_res;
                r_vd_valid <= 1'b1;
            end else if (vd_ready) begin
                r_vd_valid <= 1'b0;
            end
        end
    end

    // Each byte resolves its element index from its absolute byte position in the group
    for (genvar j = 0; j < BYTES; j++) begin : g_byte
        localparam logic [2:0] JL = 3'(j % 8);
        logic [VLW-1:0] w_bidx, w_idx;
        logic [2:0]     w_sb;
        logic           w_m;
        logic [7:0]     w_b;

        always_comb begin
            w_bidx = VLW'(r_beat) * VLW'(BYTES) + VLW'(j);
            w_idx  = w_bidx >> r_sew;
            w_m    = r_v0[w_idx[VSW-1:0]];
            case (r_sew)
                2'd0:    w_sb = 3'd0;
                2'd1:    w_sb = JL & 3'b001;
                2'd2:    w_sb = JL & 3'b011;
                default: w_sb = JL;
            endcase
            if (w_idx < {1'b0, r_vstart}) begin
                w_b = old_vd[j*8 +: 8];
            end else if (w_idx < r_vl) begin
                case (r_mode)
                    M_VVM:   w_b = w_m ? vs1[j*8 +: 8] : vs2[j*8 +: 8];
                    M_VXM:   w_b = w_m ? r_scalar[w_sb] : vs2[j*8 +: 8];
                    M_VMV_V: w_b = vs1[j*8 +: 8];
                    default: w_b = r_scalar[w_sb];
                endcase
            end else begin
                w_b = r_ta ? 8'hFF : old_vd[j*8 +: 8];
            end
        end

        assign w_res[j] = w_b;
    end
endmodule
